// File: rtl/mem_pkg.sv
// Shared definitions for the load/store stage: size codes, FSM states, request legality.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StDone = 2'b10
  } state_e;

  // A request is illegal if it is both a load and a store, uses the reserved size code,
  // or is not naturally aligned for its size.
  function automatic logic req_illegal(input logic       rd,
                                       input logic       wr,
                                       input logic [1:0] sz,
                                       input logic [1:0] addr_lo);
    logic bad;
    bad = rd & wr;
    if (sz == 2'b11) bad = 1'b1;
    if ((sz == SZ_HALF) && addr_lo[0]) bad = 1'b1;
    if ((sz == SZ_WORD) && (addr_lo != 2'b00)) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables and data replication, load lane select and extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        sign_ext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign rd_half = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  // Lane decode for both the store (enables, replicated data) and load (extract, extend) paths.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_ext_i & rd_byte[7]}}, rd_byte};
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sign_ext_i & rd_half[15]}}, rd_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: issues one bus access per legal request, stalls until ack or timeout.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        fault,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              stall_c, fault_c;

  logic              idle;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata, al_rdata;

  // In IDLE the aligner sees the live request; in WAIT it sees the fields latched at accept.
  assign idle = (state_q == StIdle);

  mem_lane_align u_align (
    .size_i     (idle ? size : size_q),
    .addr_lo_i  (idle ? addr_in[1:0] : addr_lo_q),
    .sign_ext_i (idle ? sign_ext : sext_q),
    .wdata_i    (wdata_in),
    .rdata_i    (bus_rdata),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

  // Next-state, capture and combinational stall/fault.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    addr_lo_d = addr_lo_q;
    size_d    = size_q;
    sext_d    = sext_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    stall_c   = 1'b0;
    fault_c   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_read | mem_write) begin
          if (req_illegal(mem_read, mem_write, size, addr_in[1:0])) begin
            fault_c = 1'b1;
          end else begin
            stall_c   = 1'b1;
            state_d   = StWait;
            cnt_d     = '0;
            req_d     = 1'b1;
            we_d      = mem_write;
            addr_d    = {addr_in[31:2], 2'b00};
            addr_lo_d = addr_in[1:0];
            size_d    = size;
            sext_d    = sign_ext;
            be_d      = al_be;
            wdata_d   = al_wdata;
            err_d     = 1'b0;
          end
        end
      end
      StWait: begin
        stall_c = 1'b1;
        // Ack takes priority over a timeout in the same cycle.
        if (bus_ack) begin
          req_d   = 1'b0;
          rdata_d = we_q ? 32'd0 : al_rdata;
          state_d = StDone;
        end else if (cnt_q == TimeoutCnt) begin
          req_d   = 1'b0;
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        // Same instruction is still on the inputs here, so nothing is re-issued.
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      addr_lo_q <= '0;
      size_q    <= '0;
      sext_q    <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      addr_lo_q <= addr_lo_d;
      size_q    <= size_d;
      sext_q    <= sext_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Nothing is accepted or flagged while reset is held.
  assign stall     = stall_c & rst_n;
  assign fault     = fault_c & rst_n;
  assign rdata_out = rdata_q;
  assign bus_err   = err_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit against a small arithmetic reference model.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr_in, wdata_in, bus_rdata;
  logic        mem_read, mem_write, sign_ext, bus_ack;
  logic [1:0]  size;
  logic        stall, fault, bus_err, bus_req, bus_we;
  logic [31:0] rdata_out, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  int          n_run  = 0;
  int          n_fail = 0;
  logic [31:0] exp_rdata = 32'd0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .size      (size),
    .sign_ext  (sign_ext),
    .stall     (stall),
    .rdata_out (rdata_out),
    .fault     (fault),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  // ---------------- reference model ----------------
  function automatic bit m_illegal(bit rd, bit wr, int sz, int a);
    if (rd && wr) return 1;
    if (sz == 3) return 1;
    if (sz == 1 && (a % 2) != 0) return 1;
    if (sz == 2 && (a % 4) != 0) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] m_be(int sz, int a);
    int lo = a % 4;
    if (sz == 0) return 4'(1 << lo);
    if (sz == 1) return 4'(3 << lo);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(int sz, logic [31:0] wd);
    if (sz == 0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(int sz, int a, bit sext, logic [31:0] rd);
    logic [31:0] v;
    int lo = a % 4;
    if (sz == 0) begin
      v = (rd >> (8 * lo)) & 32'hFF;
      if (sext && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (rd >> (8 * lo)) & 32'hFFFF;
      if (sext && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // One complete transaction; ack_at is the WAIT cycle (1-based) carrying bus_ack.
  task automatic run_access(input string tag, input bit rd, input bit wr, input logic [1:0] sz,
                            input bit sext, input logic [31:0] addr, input logic [31:0] wd,
                            input int ack_at, input logic [31:0] mem_rd, input bit scramble);
    int nwait;
    bit tmo;
    @(negedge clk);
    mem_read = rd; mem_write = wr; size = sz; sign_ext = sext;
    addr_in = addr; wdata_in = wd; bus_ack = 1'b0;
    #1;
    if (m_illegal(rd, wr, int'(sz), int'(addr[1:0]))) begin
      n_run++;
      if ({fault, stall, bus_req} !== 3'b100) begin
        n_fail++;
        $display("FAIL %s illegal: fault/stall/req=%b required 100", tag, {fault, stall, bus_req});
      end
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
      n_run++;
      if ({fault, stall, bus_req, bus_err, rdata_out} !== {4'b0000, exp_rdata}) begin
        n_fail++;
        $display("FAIL %s after_fault: f/s/r/e=%b rdata=%h required 0000 %h", tag,
                 {fault, stall, bus_req, bus_err}, rdata_out, exp_rdata);
      end
      return;
    end
    n_run++;
    if ({fault, stall, bus_req} !== 3'b010) begin
      n_fail++;
      $display("FAIL %s accept: fault/stall/req=%b required 010", tag, {fault, stall, bus_req});
    end
    nwait = (ack_at <= int'(TO) + 1) ? ack_at : int'(TO) + 1;
    tmo   = (ack_at > int'(TO) + 1);
    for (int w = 1; w <= nwait; w++) begin
      @(negedge clk);
      n_run++;
      if ({stall, bus_req, fault, bus_err, bus_we, bus_addr, bus_be, bus_wdata} !==
          {1'b1, 1'b1, 1'b0, 1'b0, wr, addr & 32'hFFFF_FFFC, m_be(int'(sz), int'(addr[1:0])),
           m_wdata(int'(sz), wd)}) begin
        n_fail++;
        $display("FAIL %s wait%0d: s/r/f/e/we=%b addr=%h be=%b wd=%h required 1100%b %h %b %h",
                 tag, w, {stall, bus_req, fault, bus_err, bus_we}, bus_addr, bus_be, bus_wdata,
                 wr, addr & 32'hFFFF_FFFC, m_be(int'(sz), int'(addr[1:0])), m_wdata(int'(sz), wd));
      end
      if (scramble) begin
        addr_in = $urandom; wdata_in = $urandom;
        size = 2'($urandom_range(0, 3)); sign_ext = 1'($urandom_range(0, 1));
      end
      bus_ack   = (w == ack_at);
      bus_rdata = (w == ack_at) ? mem_rd : $urandom;
    end
    @(negedge clk);
    bus_ack = 1'b0;
    exp_rdata = (tmo || wr) ? 32'd0 : m_load(int'(sz), int'(addr[1:0]), sext, mem_rd);
    n_run++;
    if ({stall, bus_req, fault, bus_err, rdata_out} !== {3'b000, tmo, exp_rdata}) begin
      n_fail++;
      $display("FAIL %s done: s/r/f/e=%b rdata=%h required 000%b %h", tag,
               {stall, bus_req, fault, bus_err}, rdata_out, tmo, exp_rdata);
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    n_run++;
    if ({stall, bus_req, bus_err, rdata_out} !== {3'b000, exp_rdata}) begin
      n_fail++;
      $display("FAIL %s idle: s/r/e=%b rdata=%h required 000 %h", tag,
               {stall, bus_req, bus_err}, rdata_out, exp_rdata);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_run++;
    if ({stall, rdata_out, fault, bus_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: stall=%b rdata=%h req=%b addr=%h be=%b wd=%h required all 0",
               stall, rdata_out, bus_req, bus_addr, bus_be, bus_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_access("lw_0x100", 1, 0, 2'b10, 0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, 0);
    run_access("lb_sext", 1, 0, 2'b00, 1, 32'h203, 32'h0, 1, 32'h8012_3456, 0);
    run_access("lbu", 1, 0, 2'b00, 0, 32'h203, 32'h0, 2, 32'h8012_3456, 0);
    run_access("sh_0x302", 0, 1, 2'b01, 0, 32'h302, 32'h0000_ABCD, 1, 32'h1234_5678, 0);
    run_access("lh_sext", 1, 0, 2'b01, 1, 32'h402, 32'h0, 2, 32'h9ABC_0000, 0);
    run_access("sb_lane1", 0, 1, 2'b00, 0, 32'h501, 32'h1234_56A5, 1, 32'h0, 0);
  endtask

  task automatic test_illegal();
    run_access("lw_mis", 1, 0, 2'b10, 0, 32'h101, 32'h0, 1, 32'h0, 0);
    run_access("sh_mis", 0, 1, 2'b01, 0, 32'h3, 32'h0, 1, 32'h0, 0);
    run_access("size11", 1, 0, 2'b11, 0, 32'h200, 32'h0, 1, 32'h0, 0);
    run_access("rd_wr", 1, 1, 2'b10, 0, 32'h200, 32'h0, 1, 32'h0, 0);
  endtask

  task automatic test_timeout();
    run_access("timeout", 1, 0, 2'b10, 0, 32'h600, 32'h0, 1000, 32'h5555_5555, 0);
    run_access("ack_on_tmo", 1, 0, 2'b10, 0, 32'h604, 32'h0, int'(TO) + 1, 32'hCAFE_F00D, 0);
  endtask

  task automatic test_latching();
    run_access("latch_lh", 1, 0, 2'b01, 1, 32'h702, 32'h0, 4, 32'hF00F_1234, 1);
    run_access("latch_sb", 0, 1, 2'b00, 0, 32'h703, 32'h0000_00C3, 3, 32'h0, 1);
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    n_run++;
    if ({stall, bus_req, bus_err, rdata_out} !== {3'b000, exp_rdata}) begin
      n_fail++;
      $display("FAIL stray_ack_idle: s/r/e=%b rdata=%h required 000 %h",
               {stall, bus_req, bus_err}, rdata_out, exp_rdata);
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    mem_read = 1'b1; size = 2'b10; addr_in = 32'h840; sign_ext = 1'b0;
    @(negedge clk);
    n_run++;
    if (bus_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wait_req: bus_req=%b required 1", bus_req);
    end
    #1 rst_n = 1'b0;
    #1;
    n_run++;
    if ({stall, rdata_out, fault, bus_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== '0) begin
      n_fail++;
      $display("FAIL rst_wait_outputs: stall=%b req=%b addr=%h be=%b required all 0",
               stall, bus_req, bus_addr, bus_be);
    end
    mem_read = 1'b0;
    exp_rdata = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    n_run++;
    if ({stall, bus_req, bus_err, rdata_out, bus_addr} !== {3'b000, 64'd0}) begin
      n_fail++;
      $display("FAIL rst_late_ack: s/r/e=%b rdata=%h addr=%h required 000 0 0",
               {stall, bus_req, bus_err}, rdata_out, bus_addr);
    end
    run_access("after_rst", 1, 0, 2'b10, 0, 32'h900, 32'h0, 1, 32'h2468_ACE0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int unsigned r;
      bit rd, wr;
      logic [1:0] sz;
      logic [31:0] a;
      r  = $urandom_range(0, 9);
      rd = (r == 0) || (r < 5);
      wr = (r == 0) || (r >= 5);
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b10) a[1:0] = 2'b00;
        else if (sz == 2'b01) a[0] = 1'b0;
      end
      run_access($sformatf("rand%0d", i), rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom,
                 int'($urandom_range(1, 7)), $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    addr_in = '0; wdata_in = '0; bus_rdata = '0;
    mem_read = 1'b0; mem_write = 1'b0; sign_ext = 1'b0; bus_ack = 1'b0; size = 2'b00;
    test_reset();
    test_directed();
    test_illegal();
    test_timeout();
    test_latching();
    test_stray_ack();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
